uart_tx_frame: RTL

UART_TX_FRAME -- requirements
Module: uart_tx_frame

---
 rtl/uart_tx_frame.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter framing one data word per frame.
// One-entry holding register in front of a shift register, LSB first, with
// start bit, DATA_WIDTH data bits, optional parity bit and STOP_BITS stop bits.
// Optional parity is compiled in with the macro UART_TX_PARITY_EN.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  parity_odd,
    output logic                  data_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [0:0]            stop_cnt_q, stop_cnt_d;
    logic                  load_c;
    logic                  accept_c;

`ifdef UART_TX_PARITY_EN
    logic                  hold_odd_q, hold_odd_d;
    logic                  par_bit_q, par_bit_d;
`else
    // Parity select has no function without the parity stage.
    logic                  unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // Next-state, holding-register and serial-line logic.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        load_c      = 1'b0;
        accept_c    = data_valid && ready_q;
`ifdef UART_TX_PARITY_EN
        hold_odd_d  = hold_odd_q;
        par_bit_d   = par_bit_q;
`endif

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_full_q) begin
                        load_c = 1'b1;
                    end
                end
                S_START: begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
                S_DATA: begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_bit_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                        stop_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = '0;
                end
`endif
                S_STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Move the held word into the shifter and emit the start bit.
        if (load_c) begin
            state_d     = S_START;
            tx_d        = 1'b0;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit_d   = (^hold_q) ^ hold_odd_q;
`endif
        end

        // A load needs hold_full, an accept needs it clear, so they never collide.
        if (accept_c) begin
            hold_full_d = 1'b1;
            hold_d      = data_in;
`ifdef UART_TX_PARITY_EN
            hold_odd_d  = parity_odd;
`endif
        end

        ready_d = ~hold_full_d;
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous abort.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= '0;
`ifdef UART_TX_PARITY_EN
            hold_odd_q  <= 1'b0;
            par_bit_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
            hold_odd_q  <= hold_odd_d;
            par_bit_q   <= par_bit_d;
`endif
        end
    end

    assign data_ready = ready_q;
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
